// File: rtl/coll_pkg.sv
// Shared definitions for the collection sequencer.
// - State encoding for the sequencer FSM, as 3-bit constants and a typed enum.
// - Default channel count and DRAIN timeout, with the matching timeout counter width.
// - Index-width helper that stays legal for a single-channel build.
package coll_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_CLEAR  = 3'd1;
    localparam logic [2:0] ST_WINDOW = 3'd2;
    localparam logic [2:0] ST_DRAIN  = 3'd3;
    localparam logic [2:0] ST_LATCH  = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE   = ST_IDLE,
        S_CLEAR  = ST_CLEAR,
        S_WINDOW = ST_WINDOW,
        S_DRAIN  = ST_DRAIN,
        S_LATCH  = ST_LATCH,
        S_DONE   = ST_DONE
    } coll_state_e;

    localparam int NUM_CH_DEF  = 3;
    localparam int TMO_CYC_DEF = 1024;
    localparam int TMO_W       = $clog2(TMO_CYC_DEF);

    // Width of a channel index; at least one bit even when only one channel exists.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/coll_window_timer.sv
// Loadable down-counter with zero detect.
// Ports:
//   FCLK_CLK1  clock, rising edge
//   rst        asynchronous reset, active high (count -> 0)
//   load       load load_val this cycle (takes priority over dec)
//   load_val   value to load
//   dec        decrement by one; saturates at zero
//   zero       high while the count is zero (decoded from the count register)
module coll_window_timer #(
    parameter int W = 16
) (
    input  logic         FCLK_CLK1,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         zero
);

    localparam logic [W-1:0] CNT_ZERO = {W{1'b0}};
    localparam logic [W-1:0] CNT_ONE  = W'(1'b1);

    logic [W-1:0] count_r;

    // Counter register: load wins over decrement, decrement stops at zero.
    always_ff @(posedge FCLK_CLK1 or posedge rst) begin
        if (rst) begin
            count_r <= CNT_ZERO;
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != CNT_ZERO)) begin
            count_r <= count_r - CNT_ONE;
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == CNT_ZERO);

endmodule

// File: rtl/coll_sequencer.sv
// Sequences collection runs over NUM_CH max-count collector channels, one at a time.
// For each channel: clear pulse, enable window of max(win_len,1) cycles, wait for
// done (or timeout), then latch that channel's results onto the flat result buses.
// Ports:
//   FCLK_CLK1    clock, rising edge
//   rst          asynchronous reset, active high
//   start_coll   run request (level); held high gives back-to-back runs
//   win_len      window length in cycles, sampled in CLEAR; 0 behaves as 1
//   ch_done      per-channel done; only the selected channel is honoured, only in DRAIN
//   max_data_in  MaxCountData per channel, channel i at [i*DATA_ZISE +: DATA_ZISE]
//   max_cnt_in   MaxCount per channel, channel i at [i*LENGTH_ADD +: LENGTH_ADD]
//   ch_clr       one-hot 1-cycle clear pulse
//   ch_en        one-hot collection enable
//   res_data     latched MaxCountData per channel
//   res_cnt      latched MaxCount per channel
//   tmo_flags    channel timed out in the current/last run
//   busy         high whenever the FSM is not idle
//   run_done     1-cycle pulse at the end of every run
//   run_count    completed runs, wraps 255 -> 0
module coll_sequencer
    import coll_pkg::*;
#(
    parameter int DATA_ZISE  = 4,
    parameter int LENGTH_ADD = 5,
    parameter int NUM_CH     = NUM_CH_DEF,
    parameter int WIN_W      = 16,
    parameter int TMO_CYC    = TMO_CYC_DEF
) (
    input  logic                         FCLK_CLK1,
    input  logic                         rst,
    input  logic                         start_coll,
    input  logic [WIN_W-1:0]             win_len,
    input  logic [NUM_CH-1:0]            ch_done,
    input  logic [NUM_CH*DATA_ZISE-1:0]  max_data_in,
    input  logic [NUM_CH*LENGTH_ADD-1:0] max_cnt_in,
    output logic [NUM_CH-1:0]            ch_clr,
    output logic [NUM_CH-1:0]            ch_en,
    output logic [NUM_CH*DATA_ZISE-1:0]  res_data,
    output logic [NUM_CH*LENGTH_ADD-1:0] res_cnt,
    output logic [NUM_CH-1:0]            tmo_flags,
    output logic                         busy,
    output logic                         run_done,
    output logic [7:0]                   run_count
);

    localparam int TMO_CW = $clog2(TMO_CYC);
    localparam int IDX_W  = idx_width(NUM_CH);

    localparam logic [TMO_CW-1:0]          TMO_LOAD  = TMO_CW'(TMO_CYC - 1);
    localparam logic [IDX_W-1:0]           IDX_ZERO  = {IDX_W{1'b0}};
    localparam logic [IDX_W-1:0]           IDX_ONE   = IDX_W'(1'b1);
    localparam logic [IDX_W-1:0]           LAST_IDX  = IDX_W'(NUM_CH - 1);
    localparam logic [NUM_CH-1:0]          CH_ZERO   = {NUM_CH{1'b0}};
    localparam logic [NUM_CH-1:0]          ONE_HOT0  = NUM_CH'(1'b1);
    localparam logic [WIN_W-1:0]           WIN_ZERO  = {WIN_W{1'b0}};
    localparam logic [WIN_W-1:0]           WIN_ONE   = WIN_W'(1'b1);
    localparam logic [DATA_ZISE-1:0]       DATA_ZERO = {DATA_ZISE{1'b0}};
    localparam logic [LENGTH_ADD-1:0]      CNT_ZERO  = {LENGTH_ADD{1'b0}};

    coll_state_e                  state_r;
    logic [IDX_W-1:0]             idx_r;
    logic [NUM_CH-1:0]            ch_clr_r;
    logic [NUM_CH-1:0]            ch_en_r;
    logic [NUM_CH*DATA_ZISE-1:0]  res_data_r;
    logic [NUM_CH*LENGTH_ADD-1:0] res_cnt_r;
    logic [NUM_CH-1:0]            tmo_flags_r;
    logic                         busy_r;
    logic                         run_done_r;
    logic [7:0]                   run_count_r;

    logic [WIN_W-1:0]             win_load_val_s;
    logic                         win_zero_s;
    logic                         tmo_zero_s;
    logic                         done_sel_s;

    // The window counter runs from max(win_len,1)-1 down to 0, one WINDOW cycle per count.
    assign win_load_val_s = (win_len == WIN_ZERO) ? WIN_ZERO : (win_len - WIN_ONE);
    assign done_sel_s     = ch_done[idx_r];

    coll_window_timer #(.W(WIN_W)) u_win_timer (
        .FCLK_CLK1 (FCLK_CLK1),
        .rst       (rst),
        .load      (state_r == S_CLEAR),
        .load_val  (win_load_val_s),
        .dec       (state_r == S_WINDOW),
        .zero      (win_zero_s)
    );

    // Timeout counter is held at TMO_CYC-1 throughout WINDOW so DRAIN starts fully armed;
    // reaching zero in DRAIN marks the TMO_CYC-th DRAIN cycle.
    coll_window_timer #(.W(TMO_CW)) u_tmo_timer (
        .FCLK_CLK1 (FCLK_CLK1),
        .rst       (rst),
        .load      (state_r == S_WINDOW),
        .load_val  (TMO_LOAD),
        .dec       (state_r == S_DRAIN),
        .zero      (tmo_zero_s)
    );

    // Sequencer FSM with its index, flag, result and status registers.
    always_ff @(posedge FCLK_CLK1 or posedge rst) begin
        if (rst) begin
            state_r     <= S_IDLE;
            idx_r       <= IDX_ZERO;
            ch_clr_r    <= CH_ZERO;
            ch_en_r     <= CH_ZERO;
            res_data_r  <= {(NUM_CH*DATA_ZISE){1'b0}};
            res_cnt_r   <= {(NUM_CH*LENGTH_ADD){1'b0}};
            tmo_flags_r <= CH_ZERO;
            busy_r      <= 1'b0;
            run_done_r  <= 1'b0;
            run_count_r <= 8'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    run_done_r <= 1'b0;
                    if (start_coll) begin
                        state_r     <= S_CLEAR;
                        idx_r       <= IDX_ZERO;
                        tmo_flags_r <= CH_ZERO;
                        ch_clr_r    <= ONE_HOT0;
                        busy_r      <= 1'b1;
                    end else begin
                        state_r     <= S_IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                S_CLEAR: begin
                    ch_clr_r <= CH_ZERO;
                    ch_en_r  <= ONE_HOT0 << idx_r;
                    state_r  <= S_WINDOW;
                end
                S_WINDOW: begin
                    if (win_zero_s) begin
                        ch_en_r <= CH_ZERO;
                        state_r <= S_DRAIN;
                    end else begin
                        state_r <= S_WINDOW;
                    end
                end
                S_DRAIN: begin
                    // A done arriving on the timeout cycle still counts as a clean finish.
                    if (done_sel_s) begin
                        state_r <= S_LATCH;
                    end else if (tmo_zero_s) begin
                        tmo_flags_r[idx_r] <= 1'b1;
                        state_r            <= S_LATCH;
                    end else begin
                        state_r <= S_DRAIN;
                    end
                end
                S_LATCH: begin
                    if (tmo_flags_r[idx_r]) begin
                        res_data_r[idx_r*DATA_ZISE +: DATA_ZISE]  <= DATA_ZERO;
                        res_cnt_r[idx_r*LENGTH_ADD +: LENGTH_ADD] <= CNT_ZERO;
                    end else begin
                        res_data_r[idx_r*DATA_ZISE +: DATA_ZISE]  <= max_data_in[idx_r*DATA_ZISE +: DATA_ZISE];
                        res_cnt_r[idx_r*LENGTH_ADD +: LENGTH_ADD] <= max_cnt_in[idx_r*LENGTH_ADD +: LENGTH_ADD];
                    end
                    if (idx_r == LAST_IDX) begin
                        state_r     <= S_DONE;
                        run_done_r  <= 1'b1;
                        run_count_r <= run_count_r + 8'd1;
                    end else begin
                        idx_r    <= idx_r + IDX_ONE;
                        ch_clr_r <= ONE_HOT0 << (idx_r + IDX_ONE);
                        state_r  <= S_CLEAR;
                    end
                end
                S_DONE: begin
                    run_done_r <= 1'b0;
                    // Continuous mode: go straight into the next run without an idle cycle.
                    if (start_coll) begin
                        state_r     <= S_CLEAR;
                        idx_r       <= IDX_ZERO;
                        tmo_flags_r <= CH_ZERO;
                        ch_clr_r    <= ONE_HOT0;
                    end else begin
                        state_r     <= S_IDLE;
                        busy_r      <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= S_IDLE;
                    idx_r      <= IDX_ZERO;
                    ch_clr_r   <= CH_ZERO;
                    ch_en_r    <= CH_ZERO;
                    busy_r     <= 1'b0;
                    run_done_r <= 1'b0;
                end
            endcase
        end
    end

    assign ch_clr    = ch_clr_r;
    assign ch_en     = ch_en_r;
    assign res_data  = res_data_r;
    assign res_cnt   = res_cnt_r;
    assign tmo_flags = tmo_flags_r;
    assign busy      = busy_r;
    assign run_done  = run_done_r;
    assign run_count = run_count_r;

endmodule

// File: tb/tb_coll_sequencer.sv
// Directed testbench for coll_sequencer (NUM_CH=3, DATA_ZISE=4, LENGTH_ADD=5, TMO_CYC=16).
module tb_coll_sequencer;

    logic        FCLK_CLK1;
    logic        rst;
    logic        start_coll;
    logic [15:0] win_len;
    logic [2:0]  ch_done;
    logic [11:0] max_data_in;
    logic [14:0] max_cnt_in;
    logic [2:0]  ch_clr;
    logic [2:0]  ch_en;
    logic [11:0] res_data;
    logic [14:0] res_cnt;
    logic [2:0]  tmo_flags;
    logic        busy;
    logic        run_done;
    logic [7:0]  run_count;

    logic [2:0]  done_mask;

    int n_checks = 0;
    int n_pass   = 0;

    int clr_cnt[3] = '{0, 0, 0};
    int en_cnt[3]  = '{0, 0, 0};
    int rd_cnt     = 0;
    int overlap_cnt = 0;
    int multi_cnt  = 0;
    int s_clr[3];
    int s_en[3];
    int s_rd;

    coll_sequencer #(
        .DATA_ZISE  (4),
        .LENGTH_ADD (5),
        .NUM_CH     (3),
        .WIN_W      (16),
        .TMO_CYC    (16)
    ) dut (
        .FCLK_CLK1   (FCLK_CLK1),
        .rst         (rst),
        .start_coll  (start_coll),
        .win_len     (win_len),
        .ch_done     (ch_done),
        .max_data_in (max_data_in),
        .max_cnt_in  (max_cnt_in),
        .ch_clr      (ch_clr),
        .ch_en       (ch_en),
        .res_data    (res_data),
        .res_cnt     (res_cnt),
        .tmo_flags   (tmo_flags),
        .busy        (busy),
        .run_done    (run_done),
        .run_count   (run_count)
    );

    initial FCLK_CLK1 = 1'b0;
    always #5 FCLK_CLK1 = ~FCLK_CLK1;

    // Collector model: pulse done for 1 cycle, 2 cycles after a channel's window ends.
    initial begin : responder
        logic [2:0] en_prev;
        logic [2:0] pend;
        int         dly;
        ch_done = 3'b000;
        en_prev = 3'b000;
        pend    = 3'b000;
        dly     = 0;
        forever begin
            @(negedge FCLK_CLK1);
            ch_done = 3'b000;
            if (dly > 0) begin
                dly = dly - 1;
                if (dly == 0) ch_done = pend;
            end
            if (en_prev != 3'b000 && ch_en == 3'b000) begin
                pend = en_prev & done_mask;
                dly  = 2;
            end
            en_prev = ch_en;
        end
    end

    // Output activity counters.
    always @(negedge FCLK_CLK1) begin
        for (int i = 0; i < 3; i++) begin
            if (ch_clr[i]) clr_cnt[i]++;
            if (ch_en[i])  en_cnt[i]++;
        end
        if (run_done) rd_cnt++;
        if ((ch_clr & ch_en) != 3'b000) overlap_cnt++;
        if ($countones(ch_en) > 1 || $countones(ch_clr) > 1) multi_cnt++;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic pick(input int sel, input int b);
        case (sel)
            0:       return ch_clr[b];
            1:       return ch_en[b];
            default: return run_done;
        endcase
    endfunction

    // Advance at least one negedge, then until the chosen output reaches lvl or budget expires.
    task automatic wait_sig(input int sel, input int b, input logic lvl, input int budget, input string tag);
        int   n;
        logic v;
        n = 0;
        do begin
            @(negedge FCLK_CLK1);
            n++;
            v = pick(sel, b);
        end while (v !== lvl && n < budget);
        check_val(tag, {31'd0, v}, {31'd0, lvl});
    endtask

    task automatic snap();
        #1;
        for (int i = 0; i < 3; i++) begin
            s_clr[i] = clr_cnt[i];
            s_en[i]  = en_cnt[i];
        end
        s_rd = rd_cnt;
    endtask

    task automatic check_counts(input string tag, input int exp_en);
        #1;
        for (int i = 0; i < 3; i++) begin
            check_val($sformatf("%s_clr%0d", tag, i), 32'(clr_cnt[i] - s_clr[i]), 32'd1);
            check_val($sformatf("%s_en%0d", tag, i), 32'(en_cnt[i] - s_en[i]), 32'(exp_en));
        end
        check_val({tag, "_rd"}, 32'(rd_cnt - s_rd), 32'd1);
    endtask

    initial begin : main
        int gap;
        int k;
        rst         = 1'b1;
        start_coll  = 1'b0;
        win_len     = 16'd4;
        done_mask   = 3'b111;
        max_data_in = {4'd15, 4'd5, 4'd3};
        max_cnt_in  = {5'd31, 5'd9, 5'd17};
        repeat (3) @(negedge FCLK_CLK1);

        // Reset state
        check_val("rst_outs", {20'd0, ch_clr, ch_en, tmo_flags, busy, run_done, run_count},   32'd0);
        check_val("rst_res", {5'd0, res_data, res_cnt}, 32'd0);
        rst = 1'b0;
        @(negedge FCLK_CLK1);

        // Test 1: single run, win_len=4
        snap();
        start_coll = 1'b1;
        @(negedge FCLK_CLK1);
        check_val("t1_lat_clr", {29'd0, ch_clr}, {29'd0, 3'b001});
        check_val("t1_lat_en0", {29'd0, ch_en}, 32'd0);
        check_val("t1_busy", {31'd0, busy}, 32'd1);
        @(negedge FCLK_CLK1);
        check_val("t1_lat_en", {29'd0, ch_en}, {29'd0, 3'b001});
        check_val("t1_clr_off", {29'd0, ch_clr}, 32'd0);
        start_coll = 1'b0;
        wait_sig(2, 0, 1'b1, 200, "t1_run_done");
        check_val("t1_run_count", {24'd0, run_count}, 32'd1);
        check_val("t1_tmo", {29'd0, tmo_flags}, 32'd0);
        @(negedge FCLK_CLK1);
        check_val("t1_rd_pulse", {31'd0, run_done}, 32'd0);
        check_val("t1_idle", {31'd0, busy}, 32'd0);
        check_counts("t1", 4);
        check_val("t1_res_data", {20'd0, res_data}, {20'd0, 4'd15, 4'd5, 4'd3});
        check_val("t1_res_cnt", {17'd0, res_cnt}, {17'd0, 5'd31, 5'd9, 5'd17});

        // Test 2: win_len=0 behaves as 1
        win_len     = 16'd0;
        max_data_in = {4'd9, 4'd0, 4'd7};
        max_cnt_in  = {5'd12, 5'd30, 5'd1};
        snap();
        start_coll = 1'b1;
        wait_sig(0, 0, 1'b1, 20, "t2_clr0");
        start_coll = 1'b0;
        wait_sig(2, 0, 1'b1, 200, "t2_run_done");
        check_val("t2_run_count", {24'd0, run_count}, 32'd2);
        @(negedge FCLK_CLK1);
        check_counts("t2", 1);
        check_val("t2_res_data", {20'd0, res_data}, {20'd0, 4'd9, 4'd0, 4'd7});
        check_val("t2_res_cnt", {17'd0, res_cnt}, {17'd0, 5'd12, 5'd30, 5'd1});

        // Test 3: ch1 never done -> timeout after 16 DRAIN cycles
        done_mask   = 3'b101;
        max_data_in = {4'd2, 4'd6, 4'd1};
        max_cnt_in  = {5'd3, 5'd6, 5'd2};
        start_coll  = 1'b1;
        wait_sig(0, 0, 1'b1, 20, "t3_clr0");
        start_coll = 1'b0;
        wait_sig(1, 1, 1'b1, 100, "t3_en1_on");
        wait_sig(1, 1, 1'b0, 100, "t3_en1_off");
        gap = 0;
        while (ch_clr[2] !== 1'b1 && gap < 100) begin
            gap++;
            @(negedge FCLK_CLK1);
        end
        // 16 DRAIN cycles + 1 LATCH cycle before ch2's clear
        check_val("t3_drain_gap", 32'(gap), 32'd17);
        wait_sig(2, 0, 1'b1, 200, "t3_run_done");
        check_val("t3_tmo", {29'd0, tmo_flags}, {29'd0, 3'b010});
        check_val("t3_res_data", {20'd0, res_data}, {20'd0, 4'd2, 4'd0, 4'd1});
        check_val("t3_res_cnt", {17'd0, res_cnt}, {17'd0, 5'd3, 5'd0, 5'd2});
        check_val("t3_run_count", {24'd0, run_count}, 32'd3);

        // Test 4: continuous mode, 3 back-to-back runs
        win_len    = 16'd2;
        start_coll = 1'b1;
        wait_sig(0, 0, 1'b1, 20, "t4_clr0");
        check_val("t4_tmo_clr0", {29'd0, tmo_flags}, 32'd0);
        for (int r = 0; r < 3; r++) begin
            if (r > 0) begin
                @(negedge FCLK_CLK1);
                check_val($sformatf("t4_noidle%0d", r), {29'd0, ch_clr}, {29'd0, 3'b001});
                check_val($sformatf("t4_busy%0d", r), {31'd0, busy}, 32'd1);
                check_val($sformatf("t4_tmo_clr%0d", r), {29'd0, tmo_flags}, 32'd0);
            end
            if (r == 2) start_coll = 1'b0;
            wait_sig(2, 0, 1'b1, 200, $sformatf("t4_run_done%0d", r));
            check_val($sformatf("t4_tmo%0d", r), {29'd0, tmo_flags}, {29'd0, 3'b010});
            check_val($sformatf("t4_count%0d", r), {24'd0, run_count}, 32'(4 + r));
        end
        @(negedge FCLK_CLK1);
        check_val("t4_idle", {31'd0, busy}, 32'd0);

        // Test 5: reset mid-WINDOW on ch1
        done_mask  = 3'b111;
        win_len    = 16'd6;
        start_coll = 1'b1;
        wait_sig(1, 1, 1'b1, 100, "t5_en1");
        @(negedge FCLK_CLK1);
        snap();
        #2 rst = 1'b1;
        #1;
        check_val("t5_async_outs", {20'd0, ch_clr, ch_en, tmo_flags, busy, run_done, run_count}, 32'd0);
        check_val("t5_async_res", {5'd0, res_data, res_cnt}, 32'd0);
        repeat (2) @(negedge FCLK_CLK1);
        rst = 1'b0;
        @(negedge FCLK_CLK1);
        check_val("t5_restart_clr", {29'd0, ch_clr}, {29'd0, 3'b001});
        #1;
        check_val("t5_no_rd", 32'(rd_cnt - s_rd), 32'd0);
        start_coll = 1'b0;
        wait_sig(2, 0, 1'b1, 200, "t5_run_done");
        check_val("t5_run_count", {24'd0, run_count}, 32'd1);
        check_val("t5_res_data", {20'd0, res_data}, {20'd0, 4'd2, 4'd6, 4'd1});

        // Test 6: run_count wrap; drop start_coll mid-run
        start_coll = 1'b1;
        k = 0;
        while (run_count !== 8'd255 && k < 300) begin
            wait_sig(2, 0, 1'b1, 200, "t6_run_done");
            k++;
        end
        check_val("t6_count255", {24'd0, run_count}, 32'd255);
        snap();
        wait_sig(1, 1, 1'b1, 100, "t6_en1");
        start_coll = 1'b0;
        wait_sig(2, 0, 1'b1, 200, "t6_last_done");
        check_val("t6_wrap", {24'd0, run_count}, 32'd0);
        @(negedge FCLK_CLK1);
        check_val("t6_idle", {31'd0, busy}, 32'd0);
        check_counts("t6", 6);

        check_val("never_clr_and_en", 32'(overlap_cnt), 32'd0);
        check_val("one_hot", 32'(multi_cnt), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
